// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the framed UART transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_SNAP,
        FRM_SEND,
        FRM_DONE
    } frame_state_t;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_PARITY,
        SER_STOP
    } ser_state_t;

    function automatic int uart_divisor(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Byte serialiser: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Latency: byte accepted at edge n drives the start bit onto tx after edge n+1.
// Backpressure: byte_ready is high only while idle; one byte in flight at a time.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIVISOR   = 10,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CW = $clog2(STOP_BITS * DIVISOR + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    // tx is registered one cycle behind the state, so the idle cycle that
    // accepts the next byte supplies the final clock of the stop period.
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIVISOR - 2);
    localparam logic ODD_FLIP = (PARITY == PAR_ODD);

    ser_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          tx_q, line;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        byte_ready = 1'b0;
        line       = 1'b1;
        case (state_q)
            SER_IDLE: begin
                byte_ready = 1'b1;
                cnt_d      = '0;
                if (byte_valid) begin
                    state_d = SER_START;
                    shreg_d = byte_i;
                    par_d   = (^byte_i) ^ ODD_FLIP;
                end
            end
            SER_START: begin
                line = 1'b0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SER_DATA;
                end
            end
            SER_DATA: begin
                line = shreg_q[0];
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? SER_PARITY : SER_STOP;
                    end
                end
            end
            SER_PARITY: begin
                line = par_q;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = SER_STOP;
                end
            end
            SER_STOP: begin
                line = 1'b1;
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= line;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_frame_tx.sv
// Framed telemetry sender: snapshots fields_i and sends sync, N field bytes, checksum.
// Latency: trigger at edge k -> snapshot at k, sync byte handed over at k+1, tx low after k+2.
// Backpressure: bytes wait on the serialiser's ready; triggers while busy are dropped.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ   = 100000000,
    parameter int         BAUD_RATE  = 9600,
    parameter int         NUM_FIELDS = 14,
    parameter int         FIELD_W    = 6,
    parameter int         PARITY     = PAR_NONE,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
    parameter int         CONTINUOUS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          start_req,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields_i,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
);

    localparam int DIVISOR = uart_divisor(CLK_FREQ, BAUD_RATE);
    localparam int IW      = $clog2(NUM_FIELDS + 2);
    localparam logic [IW-1:0] IDX_CSUM = IW'(NUM_FIELDS + 1);

    frame_state_t                  st_q, st_d;
    logic [NUM_FIELDS*FIELD_W-1:0] snap_q;
    logic [IW-1:0]                 idx_q;
    logic                          sent_q;
    logic [7:0]                    csum_q;
    logic [FIELD_W-1:0]            field_sel;
    logic [7:0]                    cur_byte;
    logic                          byte_valid, byte_ready, xfer;
    logic                          trigger, snap_en;

    assign trigger = enable && ((CONTINUOUS != 0) || start_req);
    assign xfer    = byte_valid && byte_ready;

    // Byte index 0 is the sync byte, 1..N the fields, N+1 the checksum.
    always_comb begin
        field_sel = '0;
        cur_byte  = SYNC_BYTE;
        if (idx_q == IDX_CSUM) begin
            cur_byte = csum_q;
        end else if (idx_q != '0) begin
            field_sel = snap_q[(int'(idx_q) - 1) * FIELD_W +: FIELD_W];
            cur_byte  = 8'(field_sel);
        end
    end

    always_comb begin
        st_d       = st_q;
        byte_valid = 1'b0;
        snap_en    = 1'b0;
        case (st_q)
            FRM_IDLE: begin
                if (trigger) begin
                    st_d    = FRM_SNAP;
                    snap_en = 1'b1;
                end
            end
            FRM_SNAP: begin
                byte_valid = 1'b1;
                if (byte_ready) st_d = FRM_SEND;
            end
            FRM_SEND: begin
                byte_valid = !sent_q;
                if (sent_q && byte_ready) st_d = FRM_DONE;
            end
            FRM_DONE: begin
                // Back-to-back frames skip IDLE to keep the inter-frame gap short.
                if ((CONTINUOUS != 0) && trigger) begin
                    st_d    = FRM_SNAP;
                    snap_en = 1'b1;
                end else begin
                    st_d = FRM_IDLE;
                end
            end
            default: st_d = FRM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q      <= FRM_IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            sent_q    <= 1'b0;
            csum_q    <= '0;
            frame_cnt <= '0;
        end else begin
            st_q <= st_d;
            if (snap_en) begin
                snap_q <= fields_i;
                csum_q <= '0;
                idx_q  <= '0;
                sent_q <= 1'b0;
            end
            if (xfer) begin
                if (idx_q == IDX_CSUM) begin
                    sent_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
                if (idx_q != '0 && idx_q != IDX_CSUM) begin
                    csum_q <= csum_q + cur_byte;
                end
            end
            if (st_q == FRM_SEND && st_d == FRM_DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign busy       = (st_q == FRM_SNAP) || (st_q == FRM_SEND);
    assign frame_done = (st_q == FRM_DONE);

    uart_tx_core #(
        .DIVISOR  (DIVISOR),
        .PARITY   (PARITY),
        .STOP_BITS(STOP_BITS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_i    (cur_byte),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three configurations, tx decoded by a UART receiver model.
module tb_uart_frame_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: 3x6-bit, no parity, 1 stop, request mode
    logic        en_a = 0, st_a = 0, tx_a, busy_a, fd_a;
    logic [17:0] f_a = '0;
    logic [15:0] cnt_a;
    // B: 4x8-bit, even parity, 2 stop, request mode
    logic        en_b = 0, st_b = 0, tx_b, busy_b, fd_b;
    logic [31:0] f_b = '0;
    logic [15:0] cnt_b;
    // C: 3x6-bit, odd parity, 1 stop, continuous
    logic        en_c = 0, st_c = 0, tx_c, busy_c, fd_c;
    logic [17:0] f_c = '0;
    logic [15:0] cnt_c;

    int ndone_a = 0, ndone_b = 0, ndone_c = 0;
    always @(negedge clk) begin
        if (fd_a === 1'b1) ndone_a <= ndone_a + 1;
        if (fd_b === 1'b1) ndone_b <= ndone_b + 1;
        if (fd_c === 1'b1) ndone_c <= ndone_c + 1;
    end

    uart_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .NUM_FIELDS(3), .FIELD_W(6), .PARITY(0),
                    .STOP_BITS(1), .SYNC_BYTE(8'hA5), .CONTINUOUS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .start_req(st_a), .fields_i(f_a),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .frame_cnt(cnt_a));

    uart_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .NUM_FIELDS(4), .FIELD_W(8), .PARITY(1),
                    .STOP_BITS(2), .SYNC_BYTE(8'hA5), .CONTINUOUS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .start_req(st_b), .fields_i(f_b),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .frame_cnt(cnt_b));

    uart_frame_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .NUM_FIELDS(3), .FIELD_W(6), .PARITY(2),
                    .STOP_BITS(1), .SYNC_BYTE(8'hA5), .CONTINUOUS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .start_req(st_c), .fields_i(f_c),
        .tx(tx_c), .busy(busy_c), .frame_done(fd_c), .frame_cnt(cnt_c));

    typedef struct packed {
        logic [17:0] flds;
        logic [7:0]  csum;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_le(input string name, input int act, input int maxv);
        checks++;
        if (act > maxv) begin
            failures++;
            $display("FAIL %s: actual=%0d required<=%0d", name, act, maxv);
        end
    endtask

    function automatic logic line_of(input int u);
        case (u)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    // Frame contents from the rules: sync, zero-extended fields, 8-bit sum of fields.
    task automatic model_frame(input logic [31:0] flat, input int n, input int fw,
                               output logic [7:0] q[$]);
        int sum;
        logic [31:0] t;
        q = {};
        sum = 0;
        q.push_back(8'hA5);
        for (int i = 0; i < n; i++) begin
            t = flat >> (i * fw);
            t = t & ((32'd1 << fw) - 32'd1);
            q.push_back(t[7:0]);
            sum += int'(t);
        end
        q.push_back(8'(sum % 256));
    endtask

    // Receiver: wait for a start edge, sample every bit at its centre.
    task automatic get_char(input int u, input int par, input int stop, input int tmo,
                            output logic [7:0] b, output logic pb, output int t0, output bit ok);
        int n;
        b = '0; pb = 1'b0; ok = 1'b1; n = 0;
        while (line_of(u) !== 1'b0 && n < tmo) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        if (line_of(u) !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (5) @(negedge clk);
        if (line_of(u) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = line_of(u);
        end
        if (par != 0) begin
            repeat (10) @(negedge clk);
            pb = line_of(u);
        end
        for (int s = 0; s < stop; s++) begin
            repeat (10) @(negedge clk);
            if (line_of(u) !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic rx_check(input int u, input string tag, input logic [7:0] exp[$],
                            input int par, input int stop,
                            output int t_first, output int t_end,
                            output logic [7:0] rb[$], output logic rp[$]);
        int clen, t;
        logic [7:0] b;
        logic pb;
        bit ok;
        clen = 10 * (10 + ((par != 0) ? 1 : 0) + (stop - 1));
        rb = {}; rp = {}; t_first = 0;
        for (int i = 0; i < exp.size(); i++) begin
            get_char(u, par, stop, 2 * clen, b, pb, t, ok);
            rb.push_back(b);
            rp.push_back(pb);
            check($sformatf("%s framing[%0d]", tag, i), 32'(ok), 32'd1);
            check($sformatf("%s byte[%0d]", tag, i), 32'(b), 32'(exp[i]));
            if (par != 0)
                check($sformatf("%s parity[%0d]", tag, i), 32'(pb),
                      32'(($countones(exp[i]) % 2) ^ ((par == 2) ? 1 : 0)));
            if (i == 0) t_first = t;
            else check($sformatf("%s char start[%0d]", tag, i), t - t_first, i * clen);
        end
        t_end = t_first + exp.size() * clen;
    endtask

    task automatic pulse_start(input int u, output int tk);
        @(negedge clk);
        case (u)
            0:       st_a = 1'b1;
            1:       st_b = 1'b1;
            default: st_c = 1'b1;
        endcase
        @(negedge clk);
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        tk = cyc;
    endtask

    task automatic expect_idle(input int u, input string name, input int ncyc);
        int lows;
        lows = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (line_of(u) !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] q[$];
        logic [7:0] rb[$];
        logic       rp[$];
        int         tk, tf, te, te_prev, nd0, exp_cnt, n;

        tbl[0] = '{flds: {6'd56, 6'd34, 6'd12}, csum: 8'h66};
        tbl[1] = '{flds: {6'd0,  6'd0,  6'd0},  csum: 8'h00};
        tbl[2] = '{flds: {6'd63, 6'd63, 6'd63}, csum: 8'hBD};
        tbl[3] = '{flds: {6'd4,  6'd2,  6'd1},  csum: 8'h07};
        tbl[4] = '{flds: {6'd1,  6'd0,  6'd63}, csum: 8'h40};

        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx_a), 32'd1);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset frame_done", 32'(fd_a), 32'd0);
        check("reset frame_cnt", 32'(cnt_a), 32'd0);
        rst_n = 1'b1;
        en_a = 1'b1;
        expect_idle(0, "A idle after reset", 20);

        // Table vectors on A
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            model_frame(32'(tbl[i].flds), 3, 6, q);
            nd0 = ndone_a;
            f_a = tbl[i].flds;
            pulse_start(0, tk);
            check($sformatf("A busy at SNAP[%0d]", i), 32'(busy_a), 32'd1);
            rx_check(0, "A tbl", q, 0, 1, tf, te, rb, rp);
            check($sformatf("A latency[%0d]", i), tf - tk, 2);
            check($sformatf("A csum[%0d]", i), 32'(rb[4]), 32'(tbl[i].csum));
            repeat (10) @(negedge clk);
            exp_cnt++;
            check($sformatf("A done pulses[%0d]", i), ndone_a - nd0, 1);
            check($sformatf("A frame_cnt[%0d]", i), 32'(cnt_a), 32'(exp_cnt));
            check($sformatf("A busy after[%0d]", i), 32'(busy_a), 32'd0);
        end

        // Random fields, altered every 7 clocks mid-frame; extra start_req while busy
        for (int r = 0; r < 4; r++) begin
            f_a = 18'($urandom);
            model_frame(32'(f_a), 3, 6, q);
            nd0 = ndone_a;
            pulse_start(0, tk);
            fork
                rx_check(0, "A rand", q, 0, 1, tf, te, rb, rp);
                begin
                    for (int j = 0; j < 70; j++) begin
                        repeat (7) @(negedge clk);
                        f_a = 18'($urandom);
                        st_a = (j == 30);
                    end
                    st_a = 1'b0;
                end
            join
            expect_idle(0, "A no queued request", 300);
            exp_cnt++;
            check("A rand done pulses", ndone_a - nd0, 1);
            check("A rand frame_cnt", 32'(cnt_a), 32'(exp_cnt));
        end

        // start_req with enable low is ignored
        en_a = 1'b0;
        pulse_start(0, tk);
        check("A disabled busy", 32'(busy_a), 32'd0);
        expect_idle(0, "A disabled no frame", 200);
        check("A disabled frame_cnt", 32'(cnt_a), 32'(exp_cnt));

        // B: even parity, two stop bits, checksum wrap
        en_b = 1'b1;
        f_b = 32'hFFFF_FFFF;
        model_frame(f_b, 4, 8, q);
        pulse_start(1, tk);
        rx_check(1, "B wrap", q, 1, 2, tf, te, rb, rp);
        check("B latency", tf - tk, 2);
        check("B checksum wrap", 32'(rb[5]), 32'hFC);
        f_b = 32'h0000_0007;
        model_frame(f_b, 4, 8, q);
        repeat (20) @(negedge clk);
        pulse_start(1, tk);
        rx_check(1, "B par", q, 1, 2, tf, te, rb, rp);
        check("B even parity of 07", 32'(rp[1]), 32'd1);
        repeat (10) @(negedge clk);
        check("B frame_cnt", 32'(cnt_b), 32'd2);

        // C: continuous frames, odd parity, enable dropped mid-frame
        f_c = {6'h2A, 6'h15, 6'h07};
        model_frame(32'(f_c), 3, 6, q);
        nd0 = ndone_c;
        en_c = 1'b1;
        te_prev = 0;
        for (int k = 0; k < 3; k++) begin
            rx_check(2, "C cont", q, 2, 1, tf, te, rb, rp);
            if (k == 0) check("C odd parity of 07", 32'(rp[1]), 32'd0);
            else check_le($sformatf("C gap[%0d]", k), tf - te_prev, 2);
            te_prev = te;
        end
        fork
            rx_check(2, "C last", q, 2, 1, tf, te, rb, rp);
            begin
                repeat (200) @(negedge clk);
                en_c = 1'b0;
            end
        join
        check_le("C gap[3]", tf - te_prev, 2);
        expect_idle(2, "C idle after disable", 300);
        check("C done pulses", ndone_c - nd0, 4);
        check("C frame_cnt", 32'(cnt_c), 32'd4);

        // Reset in the middle of a data bit, then a clean frame
        en_a = 1'b1;
        f_a = tbl[0].flds;
        pulse_start(0, tk);
        n = 0;
        while (tx_a !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("A start before reset", 32'(tx_a), 32'd0);
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-frame reset tx", 32'(tx_a), 32'd1);
        check("mid-frame reset busy", 32'(busy_a), 32'd0);
        check("mid-frame reset frame_cnt", 32'(cnt_a), 32'd0);
        rst_n = 1'b1;
        expect_idle(0, "A idle after reset", 150);
        model_frame(32'(tbl[0].flds), 3, 6, q);
        pulse_start(0, tk);
        rx_check(0, "A post-reset", q, 0, 1, tf, te, rb, rp);
        check("A post-reset latency", tf - tk, 2);
        repeat (10) @(negedge clk);
        check("A post-reset frame_cnt", 32'(cnt_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised successor of the fixed 15-byte telemetry UART sender. It serialises a coherent snapshot of NUM_FIELDS status fields as one framed packet: sync byte, data bytes, 8-bit checksum. Character format and trigger mode are configurable. It sits between the timer/state logic and the board UART pin and feeds the PC-side monitor.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate; DIVISOR = CLK_FREQ/BAUD_RATE (integer division, must be >= 4)
NUM_FIELDS, 14, data bytes per frame (1..32)
FIELD_W, 6, width of each field (1..8), zero-extended to 8 bits on the line
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
SYNC_BYTE, 8'hA5, first byte of every frame
CONTINUOUS, 1, 1 = frames back-to-back while enable is high; 0 = one frame per start_req

Ports:
clk  in  1  system clock
rst_n  in  1  reset: one clock; reset is synchronous and active-low
enable  in  1  transmitter enable
start_req  in  1  frame request pulse; used only when CONTINUOUS = 0
fields_i  in  NUM_FIELDS*FIELD_W  packed fields; field i occupies bits [i*FIELD_W +: FIELD_W]; field 0 is sent first
tx  out  1  UART line; idle high
busy  out  1  high from snapshot until the last stop bit of the frame ends
frame_done  out  1  one-cycle pulse when a frame completes
frame_cnt  out  16  number of completed frames; wraps 65535 -> 0

Behaviour:
- Reset (rst_n low at a clk edge): tx=1, busy=0, frame_done=0, frame_cnt=0; all FSMs return to IDLE and the baud counter clears. Reset mid-character drives tx high on the same edge and abandons the frame.
- Frame FSM states: IDLE, SNAP, SEND, DONE.
  - IDLE -> SNAP on a trigger: enable=1 and (CONTINUOUS=1, or start_req=1 sampled in IDLE).
  - SNAP, one cycle: registers all of fields_i, clears the checksum, sets busy=1.
  - SEND: hands bytes in order to the serialiser: SYNC_BYTE, field0..field(N-1), checksum.
  - checksum = sum mod 256 of the N zero-extended data bytes. The sync byte is excluded.
  - DONE, one cycle: frame_done=1, frame_cnt+1, busy=0. Then return to IDLE.
  - In CONTINUOUS=1 with enable held high, the next frame's SNAP follows DONE one cycle later. The line gap between frames is at most 2 clk cycles of idle high.
- start_req while busy or enable=0 is ignored, not queued. Deasserting enable mid-frame finishes the current frame, then the block stays in IDLE.
- Latency: with the trigger sampled at edge k, SNAP is at edge k, the byte is accepted by the serialiser at edge k+1, and tx goes 0 after edge k+2.
- Serialiser FSM states: IDLE, START, DATA, PARITY, STOP.
  - Handshake: byte_valid/byte_ready; a transfer happens when both are high on an edge.
  - byte_ready is high only in the serialiser's IDLE state.
  - Character: start bit 0, then 8 data bits LSB first, then a parity bit if PARITY != 0 (even: XOR of the data; odd: its inverse), then STOP_BITS stop bits of 1.
  - Each bit is held exactly DIVISOR clocks. The baud counter restarts at 0 on every start bit.
- Character length in clocks = DIVISOR*(10 + (PARITY!=0) + (STOP_BITS-1)).
- Frame length = (NUM_FIELDS+2) characters.
- Field bits above FIELD_W are 0 on the line. fields_i changes during SEND do not affect the current frame.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - frame FSM state enum
  - serialiser state enum
  - default SYNC_BYTE
  - divisor helper function (CLK_FREQ, BAUD_RATE)
- Sub-module uart_tx_core: byte serialiser with parameters DIVISOR, PARITY, STOP_BITS and ports clk, rst_n, byte_i[7:0], byte_valid, byte_ready, tx.
- The top level holds the snapshot register, byte mux, checksum accumulator and frame FSM.

Test Plan:
All tests use CLK_FREQ=1000, BAUD_RATE=100 (DIVISOR=10) for speed; the bench decodes tx with a UART model.
1. NUM_FIELDS=3, FIELD_W=6, PARITY=0, CONTINUOUS=0; fields {field0=6'd12, field1=6'd34, field2=6'd56}; start_req pulse -> bytes A5,0C,22,38,66. Each character is 100 clocks; tx falls 2 clocks after the pulse; frame_done pulses once; frame_cnt=1.
2. Same setup with PARITY=1 then PARITY=2, byte 0x07 -> parity bit 1 (even) / 0 (odd); character is 110 clocks. With STOP_BITS=2 the stop is high for 20 clocks.
3. Checksum wrap: NUM_FIELDS=4, FIELD_W=8, all fields 8'hFF -> checksum byte 0xFC.
4. Snapshot coherency: change fields_i every 7 clocks during SEND -> received bytes equal the values present at the SNAP edge.
5. CONTINUOUS=1: hold enable, receive 3 frames, gap <= 2 clocks each; drop enable mid-frame 2 -> that frame completes, then tx stays high; start_req while busy is ignored.
6. Assert rst_n=0 for one cycle mid-data-bit -> tx=1, busy=0, frame_cnt=0 at that edge; a later start_req yields a clean full frame.
